// File: rtl/jpeg_dma_seq.sv
// -----------------------------------------------------------------------------
// jpeg_dma_seq -- hardware block sequencer in front of jpeg_dma.
//
// Takes over the per-block start / start-next-block writes that the CPU would
// otherwise issue. It gates each next block on a consumer handshake, counts
// blocks, and raises a level interrupt at frame end. While the sequencer is
// idle, CPU accesses to DMA offsets 0..4 pass straight through.
//
// Optional build macro: JPEG_DMA_SEQ_TIMEOUT_EN adds a POLL watchdog that
// aborts the frame (err=1, irq=1) after TIMEOUT_CYC cycles without dct_ready.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wb_adr_i/dat_i/we_i   CPU slave access (offset = wb_adr_i[4:2])
//   seqen_i               CPU access to the DMA/sequencer window
//   wb_dat_o              CPU read data
//   dma_adr_o/dat_o/we_o  to jpeg_dma slave port
//   dma_en_o              to jpeg_dma dmaen_i
//   dma_dat_i             jpeg_dma read data (bit0 running, bit1 dct_ready)
//   blk_ready_o           a DCT block is available to the consumer
//   blk_done_i            one-cycle pulse: consumer drained the block
//   irq_o                 frame-done / error interrupt (level)
// -----------------------------------------------------------------------------
module jpeg_dma_seq #(
  parameter int BLKCNT_W    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        seqen_i,
  output logic [31:0] wb_dat_o,
  output logic [31:0] dma_adr_o,
  output logic [31:0] dma_dat_o,
  output logic        dma_we_o,
  output logic        dma_en_o,
  input  logic [31:0] dma_dat_i,
  output logic        blk_ready_o,
  input  logic        blk_done_i,
  output logic        irq_o
);

  typedef logic [BLKCNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_POLL  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] OFS_EBX    = 3'd2;
  localparam logic [2:0] OFS_EBY    = 3'd3;
  localparam logic [2:0] OFS_CTRL   = 3'd5;
  localparam logic [2:0] OFS_STATUS = 3'd6;
  localparam logic [2:0] OFS_BLKCNT = 3'd7;

  // jpeg_dma CTRL register lives at offset 4 (byte address 0x10).
  localparam logic [31:0] DMA_CTRL_ADR = 32'h0000_0010;

  // The watchdog counter is 13 bits wide; reject limits it cannot reach.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_timeout
    $error("jpeg_dma_seq: TIMEOUT_CYC must be in 1..8191");
  end

  logic [2:0] state_q, state_d;
  cnt_t       blk_cnt_q, blk_cnt_d;
  cnt_t       total_q, total_d;
  logic       blk_ready_q, blk_ready_d;
  logic       irq_q, irq_d;
  logic       err_q, err_d;
  logic [7:0] shx_q, shx_d;
  logic [7:0] shy_q, shy_d;

`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wdog_q, wdog_d;
`endif

  logic [2:0] ofs;
  logic       busy;
  logic       dma_win;
  logic       ctrl_wr;
  logic       go, irq_clr, abort;

  assign ofs     = wb_adr_i[4:2];
  assign busy    = (state_q != S_IDLE);
  assign dma_win = seqen_i && (ofs <= 3'd4);
  assign ctrl_wr = seqen_i && wb_we_i && (ofs == OFS_CTRL);
  assign go      = ctrl_wr && wb_dat_i[0];
  assign irq_clr = ctrl_wr && wb_dat_i[1];
  assign abort   = ctrl_wr && wb_dat_i[2];

  assign blk_ready_o = blk_ready_q;
  assign irq_o       = irq_q;

  // Next-state logic.
  always_comb begin
    // NOTE: every variable assigned here starts from its hold value, so no
    // branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    total_d     = total_q;
    blk_ready_d = blk_ready_q;
    irq_d       = irq_q;
    err_d       = err_q;
    shx_d       = shx_q;
    shy_d       = shy_q;
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    // Shadow the frame extent as the CPU programs it through the window.
    if (!busy && dma_win && wb_we_i) begin
      if (ofs == OFS_EBX) shx_d = wb_dat_i[7:0];
      if (ofs == OFS_EBY) shy_d = wb_dat_i[7:0];
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d   = S_START;
          blk_cnt_d = '0;
          err_d     = 1'b0;
          // Truncates to BLKCNT_W; zero means 2^BLKCNT_W blocks because the
          // DONE test below is an equality on a wrapping counter.
          total_d   = (cnt_t'(shx_q) + CNT_ONE) * (cnt_t'(shy_q) + CNT_ONE);
        end
      end
      S_START: begin
        state_d = S_POLL;
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_POLL: begin
        if (dma_dat_i[1]) begin
          state_d     = S_HOLD;
          blk_ready_d = 1'b1;
          blk_cnt_d   = blk_cnt_q + CNT_ONE;
        end
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          irq_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 13'd1;
        end
`endif
      end
      S_HOLD: begin
        if (blk_done_i) begin
          state_d     = S_NEXT;
          blk_ready_d = 1'b0;
        end
      end
      S_NEXT: begin
        state_d = (blk_cnt_q == total_q) ? S_DONE : S_POLL;
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        irq_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over anything the FSM decided this cycle; jpeg_dma itself
    // is left alone and must be re-armed by software.
    if (abort && busy) begin
      state_d     = S_IDLE;
      blk_ready_d = 1'b0;
      err_d       = 1'b1;
      irq_d       = irq_q;
    end

    if (irq_clr) irq_d = 1'b0;
  end

  // DMA port mux and CPU read data.
  always_comb begin
    dma_adr_o = '0;
    dma_dat_o = '0;
    dma_we_o  = 1'b0;
    dma_en_o  = 1'b0;
    wb_dat_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (dma_win) begin
          dma_adr_o = wb_adr_i;
          dma_dat_o = wb_dat_i;
          dma_we_o  = wb_we_i;
          dma_en_o  = 1'b1;
          wb_dat_o  = dma_dat_i;
        end
      end
      S_START: begin
        dma_adr_o = DMA_CTRL_ADR;
        dma_dat_o = 32'h1;
        dma_we_o  = 1'b1;
        dma_en_o  = 1'b1;
      end
      S_POLL: begin
        dma_adr_o = DMA_CTRL_ADR;
        dma_en_o  = 1'b1;
      end
      S_NEXT: begin
        dma_adr_o = DMA_CTRL_ADR;
        dma_dat_o = 32'h2;
        dma_we_o  = 1'b1;
        dma_en_o  = 1'b1;
      end
      default: ;
    endcase

    if (seqen_i) begin
      case (ofs)
        OFS_STATUS: wb_dat_o = {28'b0, err_q, irq_q, blk_ready_q, busy};
        OFS_BLKCNT: wb_dat_o = 32'(blk_cnt_q);
        default: ;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      blk_cnt_q   <= '0;
      total_q     <= '0;
      blk_ready_q <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      shx_q       <= '0;
      shy_q       <= '0;
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      total_q     <= total_d;
      blk_ready_q <= blk_ready_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

endmodule
